// File: rtl/hier_icache_maint_sequencer.sv
// Fans one icache maintenance command out to all L2 banks, then to a mask of L1 caches.
// Latency: reqs one cycle after accept; done one cycle after the last ack (or timeout) of the final phase.
// Backpressure: cmd_ready_o only in IDLE; each target holds its req until it acks or the phase times out.
module hier_icache_maint_sequencer #(
    parameter int NB_CACHE_BANKS = 4,
    parameter int NB_CORES       = 9,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               cmd_valid_i,
    output logic                               cmd_ready_o,
    input  logic [2:0]                         cmd_op_i,
    input  logic [NB_CORES-1:0]                cmd_core_mask_i,
    input  logic [31:0]                        cmd_addr_i,
    output logic                               done_o,
    output logic                               err_o,
    output logic [NB_CACHE_BANKS+NB_CORES-1:0] err_pending_o,
    output logic [NB_CACHE_BANKS-1:0]          l2_enable_req_o,
    input  logic [NB_CACHE_BANKS-1:0]          l2_enable_ack_i,
    output logic [NB_CACHE_BANKS-1:0]          l2_disable_req_o,
    input  logic [NB_CACHE_BANKS-1:0]          l2_disable_ack_i,
    output logic [NB_CACHE_BANKS-1:0]          l2_flush_req_o,
    input  logic [NB_CACHE_BANKS-1:0]          l2_flush_ack_i,
    output logic [NB_CACHE_BANKS-1:0]          l2_sel_flush_req_o,
    input  logic [NB_CACHE_BANKS-1:0]          l2_sel_flush_ack_i,
    output logic [NB_CORES-1:0]                l1_flush_req_o,
    input  logic [NB_CORES-1:0]                l1_flush_ack_i,
    output logic [NB_CORES-1:0]                l1_sel_flush_req_o,
    input  logic [NB_CORES-1:0]                l1_sel_flush_ack_i,
    output logic [31:0]                        sel_flush_addr_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [2:0] OP_L2_ENABLE  = 3'd0;
    localparam logic [2:0] OP_L2_DISABLE = 3'd1;
    localparam logic [2:0] OP_L2_FLUSH   = 3'd2;
    localparam logic [2:0] OP_L1_FLUSH   = 3'd3;
    localparam logic [2:0] OP_FULL_FLUSH = 3'd4;
    localparam logic [2:0] OP_SEL_FLUSH  = 3'd5;

    typedef enum logic [1:0] {S_IDLE, S_L2_WAIT, S_L1_WAIT, S_DONE} state_t;

    state_t                              state_q, state_d;
    logic [2:0]                          op_q, op_d;
    logic [NB_CORES-1:0]                 mask_q, mask_d;
    logic [31:0]                         addr_q, addr_d;
    logic [NB_CACHE_BANKS-1:0]           l2_pend_q, l2_pend_d;
    logic [NB_CORES-1:0]                 l1_pend_q, l1_pend_d;
    logic [CNT_W-1:0]                    cnt_q, cnt_d;
    logic                                err_q, err_d;
    logic [NB_CACHE_BANKS+NB_CORES-1:0]  err_pend_q, err_pend_d;

    logic [NB_CACHE_BANKS-1:0]           l2_ack, l2_left;
    logic [NB_CORES-1:0]                 l1_ack, l1_left;
    logic                                has_l1, timeout_hit;

    // Only the ack bus matching the latched op can retire pending bits.
    always_comb begin
        l2_ack = '0;
        l1_ack = '0;
        case (op_q)
            OP_L2_ENABLE:  l2_ack = l2_enable_ack_i;
            OP_L2_DISABLE: l2_ack = l2_disable_ack_i;
            OP_L2_FLUSH:   l2_ack = l2_flush_ack_i;
            OP_L1_FLUSH:   l1_ack = l1_flush_ack_i;
            OP_FULL_FLUSH: begin
                l2_ack = l2_flush_ack_i;
                l1_ack = l1_flush_ack_i;
            end
            OP_SEL_FLUSH: begin
                l2_ack = l2_sel_flush_ack_i;
                l1_ack = l1_sel_flush_ack_i;
            end
            default: ;
        endcase
    end

    assign l2_left     = l2_pend_q & ~l2_ack;
    assign l1_left     = l1_pend_q & ~l1_ack;
    assign has_l1      = (op_q == OP_FULL_FLUSH) || (op_q == OP_SEL_FLUSH);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        mask_d     = mask_q;
        addr_d     = addr_q;
        l2_pend_d  = l2_pend_q;
        l1_pend_d  = l1_pend_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        err_pend_d = err_pend_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    op_d       = cmd_op_i;
                    mask_d     = cmd_core_mask_i;
                    addr_d     = cmd_addr_i;
                    cnt_d      = '0;
                    err_d      = 1'b0;
                    err_pend_d = '0;
                    case (cmd_op_i)
                        OP_L2_ENABLE, OP_L2_DISABLE, OP_L2_FLUSH,
                        OP_FULL_FLUSH, OP_SEL_FLUSH: begin
                            l2_pend_d = '1;
                            state_d   = S_L2_WAIT;
                        end
                        OP_L1_FLUSH: begin
                            l1_pend_d = cmd_core_mask_i;
                            state_d   = (cmd_core_mask_i == '0) ? S_DONE : S_L1_WAIT;
                        end
                        default: begin
                            err_d   = 1'b1;
                            state_d = S_DONE;
                        end
                    endcase
                end
            end
            S_L2_WAIT: begin
                l2_pend_d = l2_left;
                cnt_d     = cnt_q + 1'b1;
                if (l2_left == '0) begin
                    cnt_d = '0;
                    if (has_l1) begin
                        // An empty L1 mask skips the L1 phase entirely.
                        l1_pend_d = mask_q;
                        state_d   = (mask_q == '0) ? S_DONE : S_L1_WAIT;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (timeout_hit) begin
                    err_d      = 1'b1;
                    err_pend_d = {{NB_CORES{1'b0}}, l2_left};
                    l2_pend_d  = '0;
                    state_d    = S_DONE;
                end
            end
            S_L1_WAIT: begin
                l1_pend_d = l1_left;
                cnt_d     = cnt_q + 1'b1;
                if (l1_left == '0) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else if (timeout_hit) begin
                    err_d      = 1'b1;
                    err_pend_d = {l1_left, {NB_CACHE_BANKS{1'b0}}};
                    l1_pend_d  = '0;
                    state_d    = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            mask_q     <= '0;
            addr_q     <= '0;
            l2_pend_q  <= '0;
            l1_pend_q  <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            err_pend_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            mask_q     <= mask_d;
            addr_q     <= addr_d;
            l2_pend_q  <= l2_pend_d;
            l1_pend_q  <= l1_pend_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            err_pend_q <= err_pend_d;
        end
    end

    // Pending registers are nonzero only inside their own phase, so reqs are gated by op alone.
    assign l2_enable_req_o    = (op_q == OP_L2_ENABLE)  ? l2_pend_q : '0;
    assign l2_disable_req_o   = (op_q == OP_L2_DISABLE) ? l2_pend_q : '0;
    assign l2_flush_req_o     = (op_q == OP_L2_FLUSH || op_q == OP_FULL_FLUSH) ? l2_pend_q : '0;
    assign l2_sel_flush_req_o = (op_q == OP_SEL_FLUSH)  ? l2_pend_q : '0;
    assign l1_flush_req_o     = (op_q == OP_L1_FLUSH || op_q == OP_FULL_FLUSH) ? l1_pend_q : '0;
    assign l1_sel_flush_req_o = (op_q == OP_SEL_FLUSH)  ? l1_pend_q : '0;

    assign sel_flush_addr_o = addr_q;
    assign cmd_ready_o      = (state_q == S_IDLE);
    assign done_o           = (state_q == S_DONE);
    assign err_o            = (state_q == S_DONE) && err_q;
    assign err_pending_o    = (state_q == S_DONE) ? err_pend_q : '0;

endmodule

// File: tb/tb_hier_icache_maint_sequencer.sv
// Bench for hier_icache_maint_sequencer: command table, directed corner sequences, and random traffic
// checked every cycle against a phase-queue model of the sequencer.
module tb_hier_icache_maint_sequencer;

    localparam int NB = 4;
    localparam int NC = 9;
    localparam int TO = 16;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            cmd_valid_i;
    logic            cmd_ready_o;
    logic [2:0]      cmd_op_i;
    logic [NC-1:0]   cmd_core_mask_i;
    logic [31:0]     cmd_addr_i;
    logic            done_o, err_o;
    logic [NB+NC-1:0] err_pending_o;
    logic [NB-1:0]   l2_enable_req_o, l2_enable_ack_i, l2_disable_req_o, l2_disable_ack_i;
    logic [NB-1:0]   l2_flush_req_o, l2_flush_ack_i, l2_sel_flush_req_o, l2_sel_flush_ack_i;
    logic [NC-1:0]   l1_flush_req_o, l1_flush_ack_i, l1_sel_flush_req_o, l1_sel_flush_ack_i;
    logic [31:0]     sel_flush_addr_o;

    hier_icache_maint_sequencer #(
        .NB_CACHE_BANKS(NB), .NB_CORES(NC), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
        .cmd_core_mask_i(cmd_core_mask_i), .cmd_addr_i(cmd_addr_i),
        .done_o(done_o), .err_o(err_o), .err_pending_o(err_pending_o),
        .l2_enable_req_o(l2_enable_req_o), .l2_enable_ack_i(l2_enable_ack_i),
        .l2_disable_req_o(l2_disable_req_o), .l2_disable_ack_i(l2_disable_ack_i),
        .l2_flush_req_o(l2_flush_req_o), .l2_flush_ack_i(l2_flush_ack_i),
        .l2_sel_flush_req_o(l2_sel_flush_req_o), .l2_sel_flush_ack_i(l2_sel_flush_ack_i),
        .l1_flush_req_o(l1_flush_req_o), .l1_flush_ack_i(l1_flush_ack_i),
        .l1_sel_flush_req_o(l1_sel_flush_req_o), .l1_sel_flush_ack_i(l1_sel_flush_ack_i),
        .sel_flush_addr_o(sel_flush_addr_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a queue of outstanding phases; the head is the one being waited on.
    // l1=0 kinds: 0 enable, 1 disable, 2 flush, 3 sel. l1=1 kinds: 0 flush, 1 sel.
    typedef struct { bit l1; int kind; logic [8:0] pend; } phase_t;
    phase_t      ph[$];
    bit          m_idle, m_done, m_err;
    logic [12:0] m_ep;
    logic [31:0] m_addr;
    int          m_wait;

    task automatic model_reset();
        ph.delete();
        m_idle = 1; m_done = 0; m_err = 0; m_ep = '0; m_addr = '0; m_wait = 0;
    endtask

    task automatic prune();
        while (ph.size() > 0 && ph[0].pend == '0) void'(ph.pop_front());
    endtask

    function automatic logic [8:0] exp_req(bit l1, int kind);
        if (!m_idle && !m_done && ph.size() > 0 && ph[0].l1 == l1 && ph[0].kind == kind)
            return ph[0].pend;
        return '0;
    endfunction

    task automatic model_step();
        phase_t     p;
        logic [8:0] a;
        if (rst_i) begin
            model_reset();
        end else if (m_done) begin
            m_done = 0;
            m_idle = 1;
        end else if (m_idle) begin
            if (cmd_valid_i) begin
                m_idle = 0; m_addr = cmd_addr_i; m_err = 0; m_ep = '0; m_wait = 0;
                case (cmd_op_i)
                    3'd0: ph.push_back('{l1: 0, kind: 0, pend: 9'h00F});
                    3'd1: ph.push_back('{l1: 0, kind: 1, pend: 9'h00F});
                    3'd2: ph.push_back('{l1: 0, kind: 2, pend: 9'h00F});
                    3'd3: ph.push_back('{l1: 1, kind: 0, pend: cmd_core_mask_i});
                    3'd4: begin
                        ph.push_back('{l1: 0, kind: 2, pend: 9'h00F});
                        ph.push_back('{l1: 1, kind: 0, pend: cmd_core_mask_i});
                    end
                    3'd5: begin
                        ph.push_back('{l1: 0, kind: 3, pend: 9'h00F});
                        ph.push_back('{l1: 1, kind: 1, pend: cmd_core_mask_i});
                    end
                    default: m_err = 1;
                endcase
                prune();
                if (ph.size() == 0) m_done = 1;
            end
        end else begin
            p = ph[0];
            if (p.l1) a = (p.kind == 0) ? l1_flush_ack_i : l1_sel_flush_ack_i;
            else case (p.kind)
                0:       a = {5'b0, l2_enable_ack_i};
                1:       a = {5'b0, l2_disable_ack_i};
                2:       a = {5'b0, l2_flush_ack_i};
                default: a = {5'b0, l2_sel_flush_ack_i};
            endcase
            p.pend = p.pend & ~a;
            ph[0]  = p;
            m_wait++;
            if (p.pend == '0) begin
                void'(ph.pop_front());
                prune();
                m_wait = 0;
                if (ph.size() == 0) m_done = 1;
            end else if (m_wait == TO) begin
                m_ep  = p.l1 ? {p.pend, 4'h0} : {9'h0, p.pend[3:0]};
                m_err = 1;
                ph.delete();
                m_done = 1;
            end
        end
    endtask

    task automatic compare();
        chk("ready", cmd_ready_o, m_idle);
        chk("done", done_o, m_done);
        chk("err", err_o, m_done & m_err);
        chk("err_pending", err_pending_o, m_done ? m_ep : 13'h0);
        chk("sel_flush_addr", sel_flush_addr_o, m_addr);
        chk("l2_enable_req", l2_enable_req_o, exp_req(0, 0));
        chk("l2_disable_req", l2_disable_req_o, exp_req(0, 1));
        chk("l2_flush_req", l2_flush_req_o, exp_req(0, 2));
        chk("l2_sel_flush_req", l2_sel_flush_req_o, exp_req(0, 3));
        chk("l1_flush_req", l1_flush_req_o, exp_req(1, 0));
        chk("l1_sel_flush_req", l1_sel_flush_req_o, exp_req(1, 1));
    endtask

    // Entered and left just after a falling edge: check, clock once, advance the model.
    task automatic tick();
        compare();
        @(posedge clk_i);
        model_step();
        @(negedge clk_i);
        cyc++;
    endtask

    task automatic zero_acks();
        l2_enable_ack_i = '0; l2_disable_ack_i = '0; l2_flush_ack_i = '0; l2_sel_flush_ack_i = '0;
        l1_flush_ack_i = '0; l1_sel_flush_ack_i = '0;
    endtask

    task automatic send(input logic [2:0] op, input logic [8:0] mask, input logic [31:0] addr);
        cmd_valid_i = 1; cmd_op_i = op; cmd_core_mask_i = mask; cmd_addr_i = addr;
        tick();
        cmd_valid_i = 0;
    endtask

    typedef struct { logic [2:0] op; logic [8:0] mask; logic [31:0] addr; int lat; bit err; } vec_t;
    vec_t tbl[10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        bit got;
        tbl[0] = '{3'd0, 9'h000, 32'h0000_0001, 2, 1'b0};
        tbl[1] = '{3'd1, 9'h1FF, 32'h0000_0002, 2, 1'b0};
        tbl[2] = '{3'd2, 9'h000, 32'hDEAD_BEEF, 2, 1'b0};
        tbl[3] = '{3'd3, 9'h1A5, 32'h0000_0004, 2, 1'b0};
        tbl[4] = '{3'd3, 9'h000, 32'h0000_0005, 1, 1'b0};
        tbl[5] = '{3'd4, 9'h100, 32'h0000_0006, 3, 1'b0};
        tbl[6] = '{3'd4, 9'h000, 32'h0000_0007, 2, 1'b0};
        tbl[7] = '{3'd5, 9'h0F0, 32'hCAFE_0008, 3, 1'b0};
        tbl[8] = '{3'd6, 9'h0FF, 32'h0000_0009, 1, 1'b1};
        tbl[9] = '{3'd7, 9'h001, 32'h0000_000A, 1, 1'b1};

        rst_i = 1; cmd_valid_i = 0; cmd_op_i = '0; cmd_core_mask_i = '0; cmd_addr_i = '0;
        zero_acks();
        model_reset();
        @(negedge clk_i);
        chk("rst_ready", cmd_ready_o, 1);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_err_pending", err_pending_o, 0);
        chk("rst_addr", sel_flush_addr_o, 0);
        chk("rst_reqs", {l2_enable_req_o, l2_disable_req_o, l2_flush_req_o, l2_sel_flush_req_o,
                         l1_flush_req_o, l1_sel_flush_req_o}, 0);
        tick();
        rst_i = 0;
        tick();

        // Command table: every req is acked as soon as it is seen.
        for (int i = 0; i < 10; i++) begin
            chk("tbl_ready", cmd_ready_o, 1);
            send(tbl[i].op, tbl[i].mask, tbl[i].addr);
            got = 0;
            for (int k = 1; k <= 40 && !got; k++) begin
                l2_enable_ack_i = l2_enable_req_o; l2_disable_ack_i = l2_disable_req_o;
                l2_flush_ack_i = l2_flush_req_o; l2_sel_flush_ack_i = l2_sel_flush_req_o;
                l1_flush_ack_i = l1_flush_req_o; l1_sel_flush_ack_i = l1_sel_flush_req_o;
                if (done_o) begin
                    got = 1;
                    chk("tbl_latency", k, tbl[i].lat);
                    chk("tbl_err", err_o, tbl[i].err);
                    chk("tbl_addr", sel_flush_addr_o, tbl[i].addr);
                    chk("tbl_ready_in_done", cmd_ready_o, 0);
                end
                tick();
            end
            if (!got) chk("tbl_done_seen", done_o, 1);
            zero_acks();
            chk("tbl_ready_after", cmd_ready_o, 1);
        end

        // L2_FLUSH, bank acks at T+1, T+3, T+3, T+6.
        send(3'd2, 9'h0, 32'h0);
        for (int k = 1; k <= 8; k++) begin
            zero_acks();
            if (k == 1) l2_flush_ack_i = 4'b0001;
            if (k == 3) l2_flush_ack_i = 4'b0110;
            if (k == 6) l2_flush_ack_i = 4'b1000;
            chk("l2f_req", l2_flush_req_o, {k <= 6, k <= 3, k <= 3, k <= 1});
            chk("l2f_done", done_o, k == 7);
            if (k == 7) chk("l2f_err", err_o, 0);
            if (k == 8) chk("l2f_ready", cmd_ready_o, 1);
            tick();
        end

        // FULL_FLUSH mask 005: L2 acks at T+2, L1 acks at T+5.
        zero_acks();
        send(3'd4, 9'h005, 32'h0);
        for (int k = 1; k <= 6; k++) begin
            zero_acks();
            if (k == 2) l2_flush_ack_i = 4'hF;
            if (k == 5) l1_flush_ack_i = 9'h005;
            chk("full_l1_req", l1_flush_req_o, (k >= 3 && k <= 5) ? 9'h005 : 9'h000);
            chk("full_l2_req", l2_flush_req_o, (k <= 2) ? 4'hF : 4'h0);
            chk("full_done", done_o, k == 6);
            tick();
        end

        // SEL_FLUSH with spurious L1 acks during the L2 phase.
        zero_acks();
        send(3'd5, 9'h1FF, 32'h1C00_8040);
        for (int k = 1; k <= 4; k++) begin
            zero_acks();
            chk("sel_addr", sel_flush_addr_o, 32'h1C00_8040);
            chk("sel_l2_req", l2_sel_flush_req_o, (k <= 2) ? 4'hF : 4'h0);
            chk("sel_l1_req", l1_sel_flush_req_o, (k == 3) ? 9'h1FF : 9'h000);
            if (k <= 3) l1_sel_flush_ack_i = 9'h1FF;
            if (k == 2) l2_sel_flush_ack_i = 4'hF;
            chk("sel_done", done_o, k == 4);
            tick();
        end

        // Timeout: L1_FLUSH mask 003, core 1 never acks.
        zero_acks();
        send(3'd3, 9'h003, 32'h0);
        for (int k = 1; k <= 17; k++) begin
            l1_flush_ack_i = (k == 1) ? 9'h001 : 9'h000;
            chk("to_req", l1_flush_req_o, (k == 1) ? 9'h003 : (k <= 16) ? 9'h002 : 9'h000);
            chk("to_done", done_o, k == 17);
            if (k == 17) begin
                chk("to_err", err_o, 1);
                chk("to_err_pending", err_pending_o, 13'h020);
            end
            tick();
        end

        // cmd_valid held high while busy must not start a second command.
        zero_acks();
        cmd_valid_i = 1; cmd_op_i = 3'd0; cmd_core_mask_i = '0;
        tick();
        cmd_op_i = 3'd3; cmd_core_mask_i = 9'h1FF;
        for (int k = 1; k <= 6; k++) begin
            l2_enable_ack_i = (k == 4) ? 4'hF : 4'h0;
            if (k == 5) cmd_valid_i = 0;
            if (k <= 5) chk("busy_ready", cmd_ready_o, 0);
            chk("busy_l1_req", l1_flush_req_o, 0);
            tick();
        end
        cmd_valid_i = 0;
        zero_acks();

        // Reset pulse mid L2_WAIT, then a clean L2_ENABLE.
        send(3'd1, 9'h0, 32'h0);
        chk("rstmid_req_before", l2_disable_req_o, 4'hF);
        tick();
        rst_i = 1;
        #1;
        chk("rstmid_req_async", l2_disable_req_o, 0);
        chk("rstmid_done", done_o, 0);
        chk("rstmid_ready", cmd_ready_o, 1);
        model_reset();
        tick();
        rst_i = 0;
        tick();
        send(3'd0, 9'h0, 32'h0);
        l2_enable_ack_i = 4'hF;
        tick();
        zero_acks();
        chk("rstmid_after_done", done_o, 1);
        chk("rstmid_after_err", err_o, 0);
        tick();

        // Random traffic; quiet windows starve acks to force timeouts.
        for (int c = 0; c < 4000; c++) begin
            rst_i           = ($urandom_range(0, 499) == 0);
            cmd_valid_i     = ($urandom_range(0, 3) == 0);
            cmd_op_i        = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
            cmd_core_mask_i = ($urandom_range(0, 5) == 0) ? 9'h0 : 9'($urandom);
            cmd_addr_i      = $urandom;
            if ((c % 300) < 40) zero_acks();
            else begin
                l2_enable_ack_i    = 4'($urandom) & 4'($urandom);
                l2_disable_ack_i   = 4'($urandom) & 4'($urandom);
                l2_flush_ack_i     = 4'($urandom) & 4'($urandom);
                l2_sel_flush_ack_i = 4'($urandom) & 4'($urandom);
                l1_flush_ack_i     = 9'($urandom) & 9'($urandom);
                l1_sel_flush_ack_i = 9'($urandom) & 9'($urandom);
            end
            if (rst_i) begin
                #1;
                model_reset();
            end
            tick();
        end
        rst_i = 0;
        cmd_valid_i = 0;
        zero_acks();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
